// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - sequencing fields in, control-store address and stack status out
interface micro_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) ();

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic              en;
  logic [3:0]        p;
  logic [1:0]        cond_sel;
  logic              cond_pol;
  logic [2:0]        op;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] map_addr;
  logic              clr_err;

  logic [ADDR_W-1:0]  upc;
  logic               cond;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               err;

  // master: microinstruction/decoder side; slave: the sequencer
  modport master (
    output en, p, cond_sel, cond_pol, op, branch_addr, map_addr, clr_err,
    input  upc, cond, depth, stack_full, stack_empty, err
  );

  modport slave (
    input  en, p, cond_sel, cond_pol, op, branch_addr, map_addr, clr_err,
    output upc, cond, depth, stack_full, stack_empty, err
  );

endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - next-uPC selection with conditional jump, call/return stack and map dispatch
module micro_sequencer #(
  parameter int              ADDR_W      = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic              clk,
  input logic              rst_n,
  micro_sequencer_if.slave bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_CJMP  = 3'd2,
    OP_CALL  = 3'd3,
    OP_CCALL = 3'd4,
    OP_RET   = 3'd5,
    OP_MAP   = 3'd6,
    OP_CRET  = 3'd7
  } op_e;

  op_e               op;
  logic [ADDR_W-1:0] upc_q, upc_d, inc, top;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              cond, full, empty;
  logic              push_req, pop_req, do_push, do_pop, overflow, underflow;

  assign op    = op_e'(bus.op);
  assign cond  = bus.p[bus.cond_sel] ^ bus.cond_pol;
  assign inc   = upc_q + 1'b1;
  assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  // Index arithmetic wraps in IDX_W bits, which still lands on depth-1 when full
  assign wr_idx = depth_q[IDX_W-1:0];
  assign rd_idx = IDX_W'(depth_q - 1'b1);
  assign top    = stack_mem[rd_idx];

  always_comb begin
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (op)
      OP_CALL:  push_req = 1'b1;
      OP_CCALL: push_req = cond;
      OP_RET:   pop_req  = 1'b1;
      OP_CRET:  pop_req  = cond;
      default: ;
    endcase
  end

  assign do_push   = push_req & ~full;
  assign do_pop    = pop_req & ~empty;
  assign overflow  = push_req & full;
  assign underflow = pop_req & empty;

  // A refused push or pop falls through to inc rather than jumping
  always_comb begin
    upc_d = inc;
    case (op)
      OP_CONT:           upc_d = inc;
      OP_JMP:            upc_d = bus.branch_addr;
      OP_CJMP:           upc_d = cond ? bus.branch_addr : inc;
      OP_CALL, OP_CCALL: upc_d = do_push ? bus.branch_addr : inc;
      OP_RET, OP_CRET:   upc_d = do_pop ? top : inc;
      OP_MAP:            upc_d = bus.map_addr;
      default:           upc_d = inc;
    endcase
    if (!bus.en) begin
      upc_d = upc_q;
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (bus.en && do_push) begin
      depth_d = depth_q + 1'b1;
    end else if (bus.en && do_pop) begin
      depth_d = depth_q - 1'b1;
    end
  end

  // A fresh error wins over clr_err; clr_err works even while en is low
  always_comb begin
    err_d = err_q;
    if (bus.en && (overflow || underflow)) begin
      err_d = 1'b1;
    end else if (bus.clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q   <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      upc_q   <= upc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en && do_push) begin
      stack_mem[wr_idx] <= inc;
    end
  end

  assign bus.upc         = upc_q;
  assign bus.cond        = cond;
  assign bus.depth       = depth_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.err         = err_q;

  a_depth_bound: assert property (@(posedge clk) disable iff (!rst_n)
    depth_q <= DEPTH_W'(STACK_DEPTH));

  a_single_stack_op: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && do_pop));

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed bench with queue-based reference model and per-cycle compare
module tb_micro_sequencer;

  localparam int ADDR_W = 8;
  localparam int SD     = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   checking = 1'b0;

  micro_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(SD)) bus ();

  micro_sequencer #(
    .ADDR_W(ADDR_W),
    .STACK_DEPTH(SD),
    .RESET_ADDR(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: uPC as an integer, return stack as a queue
  int m_upc = 0;
  int m_stk[$];
  bit m_err = 1'b0;

  function automatic bit m_cond();
    return bus.p[bus.cond_sel] ^ bus.cond_pol;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int nxt;
    bit e;
    bit c;
    if (!rst_n) begin
      m_upc = 0;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      nxt = (m_upc + 1) % 256;
      e   = 1'b0;
      c   = m_cond();
      if (bus.en) begin
        case (int'(bus.op))
          1: nxt = int'(bus.branch_addr);
          2: if (c) nxt = int'(bus.branch_addr);
          3, 4: if (int'(bus.op) == 3 || c) begin
            if (m_stk.size() == SD) e = 1'b1;
            else begin
              m_stk.push_back((m_upc + 1) % 256);
              nxt = int'(bus.branch_addr);
            end
          end
          5, 7: if (int'(bus.op) == 5 || c) begin
            if (m_stk.size() == 0) e = 1'b1;
            else nxt = m_stk.pop_back();
          end
          6: nxt = int'(bus.map_addr);
          default: ;
        endcase
      end else begin
        nxt = m_upc;
      end
      if (e) m_err = 1'b1;
      else if (bus.clr_err) m_err = 1'b0;
      m_upc = nxt;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("m_upc",   bus.upc,         m_upc);
      chk("m_depth", bus.depth,       m_stk.size());
      chk("m_full",  bus.stack_full,  int'(m_stk.size() == SD));
      chk("m_empty", bus.stack_empty, int'(m_stk.size() == 0));
      chk("m_err",   bus.err,         int'(m_err));
      chk("m_cond",  bus.cond,        int'(m_cond()));
    end
  end

  task automatic op_cyc(input int o, input int ba = 0, input bit clr = 1'b0);
    bus.op          = 3'(o);
    bus.branch_addr = 8'(ba);
    bus.clr_err     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b1; bus.p = 4'b0000; bus.cond_sel = 2'd0; bus.cond_pol = 1'b0;
    bus.op = 3'd0; bus.branch_addr = '0; bus.map_addr = '0; bus.clr_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checking = 1'b1;
    chk("reset_upc", bus.upc, 0);
    chk("reset_depth", bus.depth, 0);
    chk("reset_err", bus.err, 0);

    // 1: sequential count and wrap
    for (int i = 1; i <= 5; i++) begin
      op_cyc(0);
      chk("t1_cont", bus.upc, i);
    end
    op_cyc(1, 'hFF); chk("t1_jmp_ff", bus.upc, 'hFF);
    op_cyc(0);       chk("t1_wrap", bus.upc, 'h00);

    // 2: conditional jump, both polarities
    bus.p = 4'b0100; bus.cond_sel = 2'd2; bus.cond_pol = 1'b0;
    op_cyc(2, 'h40); chk("t2_cjmp_taken", bus.upc, 'h40);
    bus.cond_pol = 1'b1;
    op_cyc(2, 'h40); chk("t2_cjmp_not", bus.upc, 'h41);
    bus.cond_pol = 1'b0;

    // 3: call / return
    op_cyc(1, 'h10);
    op_cyc(3, 'h80); chk("t3_call", bus.upc, 'h80); chk("t3_depth1", bus.depth, 1);
    op_cyc(0);       chk("t3_cont", bus.upc, 'h81);
    op_cyc(5);       chk("t3_ret", bus.upc, 'h11); chk("t3_empty", bus.stack_empty, 1);

    // 4: fill stack, overflow, sticky err, unwind with conditional ops
    for (int k = 0; k < 4; k++) op_cyc(3, 'h20 + 16 * k);
    chk("t4_upc4", bus.upc, 'h50); chk("t4_full", bus.stack_full, 1);
    op_cyc(3, 'h60); chk("t4_ovf_upc", bus.upc, 'h51);
    chk("t4_ovf_depth", bus.depth, 4); chk("t4_ovf_err", bus.err, 1);
    op_cyc(0);       chk("t4_sticky", bus.err, 1);
    op_cyc(2, 'h70); chk("t4_sticky2", bus.err, 1);
    op_cyc(0, 0, 1); chk("t4_clr", bus.err, 0); chk("t4_clr_upc", bus.upc, 'h71);
    op_cyc(5);       chk("t4_ret", bus.upc, 'h41); chk("t4_depth3", bus.depth, 3);
    bus.cond_pol = 1'b1;
    op_cyc(7);       chk("t4_cret_not", bus.upc, 'h42);
    op_cyc(4, 'h99); chk("t4_ccall_not", bus.upc, 'h43); chk("t4_depth3b", bus.depth, 3);
    bus.cond_pol = 1'b0;
    op_cyc(7);       chk("t4_cret", bus.upc, 'h31);
    op_cyc(5);       chk("t4_ret2", bus.upc, 'h21);
    op_cyc(5);       chk("t4_ret3", bus.upc, 'h12); chk("t4_depth0", bus.depth, 0);

    // 5: underflow, error beats clr_err
    op_cyc(5);       chk("t5_unf_upc", bus.upc, 'h13); chk("t5_unf_err", bus.err, 1);
    op_cyc(5, 0, 1); chk("t5_err_prio", bus.err, 1);
    op_cyc(0, 0, 1); chk("t5_clr", bus.err, 0); chk("t5_upc", bus.upc, 'h15);

    // 6: hold, async reset mid-cycle, map dispatch
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op_cyc(1, 'h33);
      chk("t6_hold", bus.upc, 'h15);
    end
    bus.en = 1'b1;
    op_cyc(3, 'h60);
    op_cyc(3, 'h70); chk("t6_depth2", bus.depth, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_upc", bus.upc, 0);
    chk("t6_arst_depth", bus.depth, 0);
    chk("t6_arst_empty", bus.stack_empty, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.map_addr = 8'h9C;
    op_cyc(6);       chk("t6_map", bus.upc, 'h9C);
    op_cyc(0);       chk("t6_after_map", bus.upc, 'h9D);

    @(posedge clk);
    #1;
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
